// File: rtl/risc16_pkg.sv
// RiSC-16 shared definitions: widths, loader state encoding and defaults.
// Imported by the instruction memory writer and the core.
package risc16_pkg;

  localparam int INSTR_W     = 16;
  localparam int IMEM_ADDR_W = 16;

  localparam logic [IMEM_ADDR_W-1:0] START_ADDR_DEF = 16'h0000;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN_HI,
    LD_LEN_LO,
    LD_DATA_HI,
    LD_DATA_LO,
    LD_CHECK,
    LD_DONE,
    LD_ERROR
  } ld_state_e;

  function automatic logic ld_active(input ld_state_e s);
    return (s == LD_LEN_HI)  || (s == LD_LEN_LO) ||
           (s == LD_DATA_HI) || (s == LD_DATA_LO) ||
           (s == LD_CHECK);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream in, big-endian 16-bit words out to the
// instruction memory write port; holds the CPU until a frame checks out.
module imem_loader
  import risc16_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = INSTR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_written
);

  ld_state_e   state;
  logic [7:0]  hi;
  logic [7:0]  csum;
  logic [15:0] remaining;
  logic        fire;
  logic [15:0] len;
  logic [15:0] word;

  // ready depends on registered state only
  assign byte_ready = ld_active(state);
  assign busy       = ld_active(state);
  assign fire       = byte_valid & byte_ready;
  assign len        = {hi, byte_data};
  assign word       = {hi, byte_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LD_IDLE;
      hi            <= '0;
      csum          <= '0;
      remaining     <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= START_ADDR;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      mem_we <= 1'b0;
      // post-write bookkeeping lands the cycle after the pulse
      if (mem_we) begin
        mem_addr      <= mem_addr + ADDR_W'(1);
        words_written <= words_written + 16'd1;
      end
      unique case (state)
        LD_IDLE, LD_DONE, LD_ERROR: begin
          if (start) begin
            state         <= LD_LEN_HI;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            csum          <= '0;
            mem_addr      <= START_ADDR;
            cpu_hold      <= 1'b1;
          end
        end
        LD_LEN_HI: begin
          if (fire) begin
            hi    <= byte_data;
            csum  <= csum ^ byte_data;
            state <= LD_LEN_LO;
          end
        end
        LD_LEN_LO: begin
          if (fire) begin
            remaining <= len;
            csum      <= csum ^ byte_data;
            state     <= (len == 16'd0) ? LD_CHECK : LD_DATA_HI;
          end
        end
        LD_DATA_HI: begin
          if (fire) begin
            hi    <= byte_data;
            csum  <= csum ^ byte_data;
            state <= LD_DATA_LO;
          end
        end
        LD_DATA_LO: begin
          if (fire) begin
            mem_wdata <= DATA_W'(word);
            mem_we    <= 1'b1;
            remaining <= remaining - 16'd1;
            csum      <= csum ^ byte_data;
            state     <= (remaining == 16'd1) ? LD_CHECK : LD_DATA_HI;
          end
        end
        LD_CHECK: begin
          if (fire) begin
            if (byte_data == csum) begin
              state    <= LD_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= LD_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule
